// File: rtl/button_debouncer.sv
// Push-button debouncer: two-flop synchronizer, stability counter, and a
// registered rising-edge pulse on the debounced level.
module button_debouncer #(
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic clean,
    output logic pos_edge
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             pos_edge_q, pos_edge_d;

    always_comb begin
        cnt_d      = '0;
        clean_d    = clean_q;
        pos_edge_d = 1'b0;
        if (sync2_q != clean_q) begin
            // Any return to the clean level lands in the default branch and
            // drops the partial count.
            if (cnt_q == CNT_MAX) begin
                clean_d    = sync2_q;
                pos_edge_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            cnt_q      <= '0;
            clean_q    <= 1'b0;
            pos_edge_q <= 1'b0;
        end else begin
            sync1_q    <= in;
            sync2_q    <= sync1_q;
            cnt_q      <= cnt_d;
            clean_q    <= clean_d;
            pos_edge_q <= pos_edge_d;
        end
    end

    assign clean    = clean_q;
    assign pos_edge = pos_edge_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4; every step drives
// in/reset, takes one rising edge and checks clean/pos_edge against hand values.
module tb_button_debouncer;

    logic clk;
    logic reset;
    logic in_r;
    logic clean;
    logic pos_edge;

    int unsigned tests;
    int unsigned fails;

    button_debouncer #(.STABLE_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in_r),
        .clean    (clean),
        .pos_edge (pos_edge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic v, input logic ec, input logic ep, input string tag);
        in_r = v;
        @(posedge clk);
        #1;
        tests++;
        assert (clean === ec) else begin
            fails++;
            $error("FAIL %s clean got %b expected %b", tag, clean, ec);
        end
        tests++;
        assert (pos_edge === ep) else begin
            fails++;
            $error("FAIL %s pos_edge got %b expected %b", tag, pos_edge, ep);
        end
    endtask

    task automatic hold(input logic v, input int unsigned n, input logic ec, input string tag);
        for (int unsigned i = 0; i < n; i++) step(v, ec, 1'b0, tag);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        in_r  = 1'b0;
        reset = 1'b0;

        hold(1'b0, 2, 1'b0, "reset_state");
        reset = 1'b1;

        hold(1'b0, 5, 1'b0, "idle_low");

        // clean rise on the 6th edge, single pulse, then quiet while held
        hold(1'b1, 5, 1'b0, "rise_wait");
        step(1'b1, 1'b1, 1'b1, "rise_edge6");
        hold(1'b1, 3, 1'b1, "rise_held");

        hold(1'b0, 5, 1'b1, "fall_wait");
        step(1'b0, 1'b0, 1'b0, "fall_edge6");
        hold(1'b0, 2, 1'b0, "fall_held");

        // bounce 1,0,1,0 then settle at 1
        step(1'b1, 1'b0, 1'b0, "bounce_1");
        step(1'b0, 1'b0, 1'b0, "bounce_2");
        step(1'b1, 1'b0, 1'b0, "bounce_3");
        step(1'b0, 1'b0, 1'b0, "bounce_4");
        hold(1'b1, 5, 1'b0, "bounce_settle");
        step(1'b1, 1'b1, 1'b1, "bounce_edge6");
        hold(1'b1, 2, 1'b1, "bounce_held");

        hold(1'b0, 5, 1'b1, "fall2_wait");
        step(1'b0, 1'b0, 1'b0, "fall2_edge6");
        hold(1'b0, 2, 1'b0, "fall2_held");

        // short pulse reaches cnt=3 but never the threshold
        hold(1'b1, 3, 1'b0, "short_high");
        hold(1'b0, 8, 1'b0, "short_after");

        hold(1'b1, 5, 1'b0, "rerise_wait");
        step(1'b1, 1'b1, 1'b1, "rerise_edge6");
        step(1'b1, 1'b1, 1'b0, "rerise_held");

        hold(1'b0, 5, 1'b1, "fall3_wait");
        step(1'b0, 1'b0, 1'b0, "fall3_edge6");
        step(1'b0, 1'b0, 1'b0, "fall3_held");

        // reset with cnt=2 and in held high through it
        hold(1'b1, 4, 1'b0, "cnt_to_2");
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, "midcount_reset");
        reset = 1'b1;
        hold(1'b1, 5, 1'b0, "post_reset_wait");
        step(1'b1, 1'b1, 1'b1, "post_reset_edge6");
        step(1'b1, 1'b1, 1'b0, "post_reset_held");

        // reset while clean is high clears it immediately
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, "reset_clears_clean");
        reset = 1'b1;
        hold(1'b1, 5, 1'b0, "rerelease_wait");
        step(1'b1, 1'b1, 1'b1, "rerelease_edge6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
